bnn_layer_sequencer: RTL and testbench
======================================

BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 3, number of chained layer stages (conv, pool, fc); legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum enabled cycles per stage before error; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to run one inference.
REQ-006 SHALL have port stage_done, input, N_STAGES, per-stage level completion flag (stage's data_out_ready).
REQ-007 SHALL have port result_ack, input, 1, consumer has taken the result; releases the pipeline.
REQ-008 SHALL have port stage_en, output, N_STAGES, per-stage level enable (stage's data_in_ready); low clears the stage.
REQ-009 SHALL have port cur_stage, output, $clog2(N_STAGES+1), index of the stage being waited on.
REQ-010 SHALL have ports busy, done, error, output, 1 each: run in progress, result valid, timeout fault.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE, ERR; all outputs registered.
REQ-012 IDLE: stage_en=0, cur_stage=0, busy=0, done=0; start=1 sampled -> RUN with stage_en=1 (bit 0 only), cur_stage=0, busy=1 after that same edge.
REQ-013 RUN: stage_en SHALL be thermometer-coded, bits 0..cur_stage high; earlier stages stay enabled to hold their outputs.
REQ-014 RUN: stage_done[cur_stage]=1 sampled with cur_stage<N_STAGES-1 -> cur_stage+1 and stage_en bit cur_stage+1 set after that edge (one-cycle hand-off latency).
REQ-015 RUN: stage_done[N_STAGES-1]=1 sampled -> DONE after that edge: done=1, busy=0, stage_en remains all ones, cur_stage=N_STAGES.
REQ-016 stage_done bits other than stage_done[cur_stage] SHALL be ignored in every state.
REQ-017 start SHALL be ignored in RUN, DONE and ERR; no queuing.
REQ-018 DONE: result_ack=1 sampled -> IDLE after that edge: stage_en=0, done=0, cur_stage=0; start and result_ack in the same cycle in DONE -> IDLE only (start dropped).
REQ-019 result_ack SHALL be ignored in IDLE and RUN.
REQ-020 A stage_done[cur_stage] already high in the first cycle its enable is high SHALL be accepted (the stage clears done while disabled).

Reset
REQ-021 rst_n=0 SHALL immediately force IDLE, stage_en=0, cur_stage=0, busy=0, done=0, error=0, watchdog counter=0, independent of clk.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abandon the run; first start after rst_n rises begins at stage 0.

Configuration
REQ-023 Macro BNN_SEQ_WATCHDOG_EN SHALL enable a per-stage watchdog; without it, ERR is unreachable, error is tied 0, no counter logic exists, and TIMEOUT_CYCLES is unused.
REQ-024 With the macro: a 16-bit counter clears on entry to RUN and on each stage advance, increments each RUN cycle; when it reaches TIMEOUT_CYCLES-1 without stage_done[cur_stage], next state is ERR.
REQ-025 With the macro: ERR sets stage_en=0, busy=0, error=1, holds cur_stage of the failed stage; result_ack -> IDLE with error=0; stage_done on the timeout cycle takes priority over timeout.

Verification (N_STAGES=3, TIMEOUT_CYCLES=16)
REQ-026 Nominal: start pulse at cycle 0; stage_done[0] at 5, [1] at 9, [2] at 20 -> stage_en 001 from 1, 011 from 6, 111 from 10; done=1 from 21; result_ack at 25 -> stage_en 000, done=0 at 26.
REQ-027 Busy start: start held high through the whole nominal run -> exactly one run; after result_ack, IDLE and next cycle start starts a new run.
REQ-028 Stale done: stage_done=3'b110 held while cur_stage=0 -> no advance until stage_done[0]=1.
REQ-029 Reset mid-run: rst_n low asynchronously at cycle 7 of nominal run -> all outputs 0 before next edge; after release, start restarts from stage_en 001.
REQ-030 Watchdog (macro on): start, never assert stage_done -> ERR entered after 16 RUN cycles, error=1, stage_en=000, cur_stage=0; result_ack -> IDLE, error=0; macro off -> busy stays 1 indefinitely, error=0.
REQ-031 Simultaneous: in DONE assert start and result_ack together -> IDLE, busy=0 next cycle, no run started.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: walks a chain of BNN layer stages (conv, pool, fc),
// enabling them one after another in thermometer order and holding the result
// until the consumer acknowledges it.
//
// Optional build macro: BNN_SEQ_WATCHDOG_EN
//   Adds a per-stage watchdog that moves the sequencer to ERR when a stage
//   stays enabled for TIMEOUT_CYCLES cycles without completing. Without the
//   macro, ERR cannot be reached, error is tied low and TIMEOUT_CYCLES is
//   only range-checked.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no run; all stages disabled (cleared)
//   RUN   | waiting on stage cur_stage; stages 0..cur_stage enabled
//   DONE  | last stage finished; result held, waiting for result_ack
//   ERR   | watchdog fired on stage cur_stage; waiting for result_ack

module bnn_layer_sequencer #(
  parameter int N_STAGES       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [N_STAGES-1:0]             stage_done,
  input  logic                            result_ack,
  output logic [N_STAGES-1:0]             stage_en,
  output logic [$clog2(N_STAGES+1)-1:0]   cur_stage,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int CW = $clog2(N_STAGES + 1);
  localparam logic [CW-1:0] LAST_STAGE = CW'(N_STAGES - 1);
  localparam logic [CW-1:0] DONE_INDEX = CW'(N_STAGES);

  if (N_STAGES < 2 || N_STAGES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("bnn_layer_sequencer: N_STAGES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cur_d;
  logic [N_STAGES-1:0] en_d;
  logic                busy_d;
  logic                done_d;
  logic                cur_done;
  logic                timeout;

  // Completion flag of the stage currently waited on; all other bits ignored.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (cur_stage == CW'(i)) cur_done = stage_done[i];
    end
  end

`ifdef BNN_SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_q;

  // A stage completing on the terminal cycle wins over the timeout.
  assign timeout = (state_q == RUN) && (wd_q == WD_LAST) && !cur_done;

  // Watchdog: restarts on entry to RUN and on every stage hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_d != RUN) begin
      wd_q <= '0;
    end else if (state_q != RUN || cur_done) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 16'd1;
    end
  end

  // Error flag is high exactly while parked in ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) error <= 1'b0;
    else        error <= (state_d == ERR);
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_stage <= '0;
      stage_en  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_stage <= cur_d;
      stage_en  <= en_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next stage index.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_stage;
    unique case (state_q)
      IDLE: begin
        cur_d = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (cur_done) begin
          if (cur_stage == LAST_STAGE) begin
            state_d = DONE;
            cur_d   = DONE_INDEX;
          end else begin
            cur_d = cur_stage + CW'(1);
          end
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        if (result_ack) begin
          state_d = IDLE;
          cur_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cur_d   = '0;
      end
    endcase
  end

  // Output values for the state being entered; registered above.
  always_comb begin
    en_d   = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      RUN: begin
        busy_d = 1'b1;
        for (int i = 0; i < N_STAGES; i++) begin
          en_d[i] = (CW'(i) <= cur_d);
        end
      end
      DONE: begin
        done_d = 1'b1;
        en_d   = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer (N_STAGES=3, TIMEOUT_CYCLES=16).
// Directed scenarios with literal expectations, then randomized traffic checked
// every cycle against a behavioural model of the sequencing rules.

module tb_bnn_layer_sequencer;

  localparam int N  = 3;
  localparam int T  = 16;
  localparam int CW = 2;

`ifdef BNN_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic          result_ack = 1'b0;
  logic [N-1:0]  stage_en;
  logic [CW-1:0] cur_stage;
  logic          busy;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bnn_layer_sequencer #(
    .N_STAGES       (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stage_done (stage_done),
    .result_ack (result_ack),
    .stage_en   (stage_en),
    .cur_stage  (cur_stage),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Behavioural model: mode 0 idle, 1 running stage m_k, 2 result held, 3 timed out.
  int m_mode = 0;
  int m_k    = 0;
  int m_wd   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_k    <= 0;
      m_wd   <= 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode <= 1;
          m_k    <= 0;
          m_wd   <= 0;
        end
        1: begin
          if (stage_done[m_k]) begin
            if (m_k == N - 1) begin
              m_mode <= 2;
              m_k    <= N;
            end else begin
              m_k  <= m_k + 1;
              m_wd <= 0;
            end
          end else if (WD && m_wd == T - 1) begin
            m_mode <= 3;
          end else begin
            m_wd <= m_wd + 1;
          end
        end
        default: if (result_ack) begin
          m_mode <= 0;
          m_k    <= 0;
        end
      endcase
    end
  end

  function automatic logic [N-1:0] model_en(int mode, int k);
    if (mode == 1) return N'((1 << (k + 1)) - 1);
    if (mode == 2) return {N{1'b1}};
    return '0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model stage_en",  32'(stage_en),  32'(model_en(m_mode, m_k)));
    check("model cur_stage", 32'(cur_stage), 32'(m_k));
    check("model busy",      32'(busy),      32'(m_mode == 1));
    check("model done",      32'(done),      32'(m_mode == 2));
    check("model error",     32'(error),     32'(m_mode == 3));
  endtask

  task automatic pin(string name, logic [N-1:0] en, int cur, bit b, bit d, bit e);
    check({name, " stage_en"},  32'(stage_en),  32'(en));
    check({name, " cur_stage"}, 32'(cur_stage), 32'(cur));
    check({name, " busy"},      32'(busy),      32'(b));
    check({name, " done"},      32'(done),      32'(d));
    check({name, " error"},     32'(error),     32'(e));
  endtask

  // One clock: inputs set before the rising edge, outputs checked at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  // Finish a run in progress with all stages completing, then acknowledge it.
  task automatic drain();
    start      = 1'b0;
    stage_done = '1;
    repeat (3) cyc();
    result_ack = 1'b1;
    stage_done = '0;
    cyc();
    result_ack = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    pin("reset", 3'b000, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Nominal run.
    for (int c = 0; c <= 27; c++) begin
      start      = (c == 0);
      stage_done = {c == 20, c == 9, c == 5};
      result_ack = (c == 25);
      cyc();
      if (c == 0)  pin("nom_c1",  3'b001, 0, 1, 0, 0);
      if (c == 4)  pin("nom_c5",  3'b001, 0, 1, 0, 0);
      if (c == 5)  pin("nom_c6",  3'b011, 1, 1, 0, 0);
      if (c == 9)  pin("nom_c10", 3'b111, 2, 1, 0, 0);
      if (c == 19) pin("nom_c20", 3'b111, 2, 1, 0, 0);
      if (c == 20) pin("nom_c21", 3'b111, 3, 0, 1, 0);
      if (c == 24) pin("nom_c25", 3'b111, 3, 0, 1, 0);
      if (c == 25) pin("nom_c26", 3'b000, 0, 0, 0, 0);
    end

    // Start held high through a whole run: one run, then a new one after the ack.
    for (int c = 0; c <= 26; c++) begin
      start      = 1'b1;
      stage_done = {c == 20, c == 9, c == 5};
      result_ack = (c == 25);
      cyc();
      if (c == 1)  pin("busy_start_c2",  3'b001, 0, 1, 0, 0);
      if (c == 22) pin("busy_start_c23", 3'b111, 3, 0, 1, 0);
      if (c == 25) pin("busy_start_idle", 3'b000, 0, 0, 0, 0);
      if (c == 26) pin("busy_start_rerun", 3'b001, 0, 1, 0, 0);
    end
    result_ack = 1'b0;
    drain();
    pin("after_drain", 3'b000, 0, 0, 0, 0);

    // Stale completion flags of later stages are ignored.
    start = 1'b1;
    cyc();
    start      = 1'b0;
    stage_done = 3'b110;
    repeat (4) cyc();
    pin("stale_hold", 3'b001, 0, 1, 0, 0);
    stage_done = 3'b001;
    cyc();
    pin("stale_adv", 3'b011, 1, 1, 0, 0);
    stage_done = 3'b101;
    cyc();
    pin("stale_hold1", 3'b011, 1, 1, 0, 0);
    stage_done = 3'b111;
    repeat (2) cyc();
    pin("stale_done", 3'b111, 3, 0, 1, 0);

    // Start and ack together in DONE: back to idle, start dropped.
    stage_done = '0;
    start      = 1'b1;
    result_ack = 1'b1;
    cyc();
    pin("simul", 3'b000, 0, 0, 0, 0);
    start      = 1'b0;
    result_ack = 1'b0;
    cyc();
    pin("simul_idle", 3'b000, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a run.
    for (int c = 0; c <= 7; c++) begin
      start      = (c == 0);
      stage_done = {1'b0, 1'b0, c == 5};
      if (c == 7) begin
        #2 rst_n = 1'b0;
        #1 pin("rst_async", 3'b000, 0, 0, 0, 0);
      end
      cyc();
    end
    pin("rst_held", 3'b000, 0, 0, 0, 0);
    rst_n      = 1'b1;
    stage_done = '0;
    start      = 1'b1;
    cyc();
    pin("rst_restart", 3'b001, 0, 1, 0, 0);
    drain();

    // No stage ever completes.
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
`ifdef BNN_SEQ_WATCHDOG_EN
      if (c == 15) pin("wd_last_run", 3'b001, 0, 1, 0, 0);
      if (c == 16) pin("wd_err",      3'b000, 0, 0, 0, 1);
`else
      if (c == 20) pin("wd_off_run",  3'b001, 0, 1, 0, 0);
`endif
    end
    result_ack = 1'b1;
    cyc();
    result_ack = 1'b0;
`ifdef BNN_SEQ_WATCHDOG_EN
    pin("wd_ack", 3'b000, 0, 0, 0, 0);
`else
    pin("ack_in_run", 3'b001, 0, 1, 0, 0);
    drain();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 3) == 0);
      stage_done = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      result_ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
